perf_monitor: RTL
=================

# perf_monitor

Synthesizable per-thread performance monitor for the multi-thread, multi-ALU RISC-V core. It sits beside the execute stage and taps each ALU's dispatch thread ID, one-hot-encoded opcode class and jump-enable. It accumulates cycles, issued instructions and taken branches/jumps per thread in saturating counters. Results are exported through snapshot registers (windowed or on request), so IPC and branch-taken rate are available in silicon, not only in simulation.

## Interface
- NUM_ALUS, 3, number of ALU lanes monitored
- NUM_THREADS, 4, hardware threads; a lane's thread ID at or above this value means idle
- TID_W, 3, thread-ID width per lane
- OH_W, 7, opcode-class code width per lane
- CNT_W, 32, width of every counter
- WIN_W, 16, window-length width
- SEL_W, $clog2(2*NUM_THREADS+1), read-select width
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  counting enable; when low, all counters and the window counter hold
- clr  in  1  clears live counters and the window counter, with no snapshot
- win_len  in  WIN_W  window length in enabled cycles; 0 selects request mode
- snap_req  in  1  snapshot request; honoured only in request mode
- alu_tid  in  NUM_ALUS*TID_W  per-lane thread ID; lane i occupies bits [i*TID_W +: TID_W]
- alu_oh  in  NUM_ALUS*OH_W  per-lane opcode class; 0 means bubble
- alu_jump_en  in  NUM_ALUS  per-lane branch-resolved-taken
- rd_sel  in  SEL_W  snapshot register select
- rd_data  out  CNT_W  selected snapshot value, registered
- snap_valid  out  1  one-cycle pulse: the snapshot bank was just updated
- sat_flag  out  1  sticky; some live counter has saturated

## Operation
- **Lane valid:** alu_tid < NUM_THREADS and alu_oh != 0.
- **Lane taken:** the lane is valid, and either alu_oh is in {3,4} (jal/jalr), or alu_oh is in 5..10 with alu_jump_en=1.
- **Per-cycle increments (only when en=1):**
  - cyc += 1.
  - inst[t] += number of valid lanes with tid=t, range 0..NUM_ALUS.
  - br[t] += number of taken lanes with tid=t.
- **Saturation:** if a sum would exceed 2^CNT_W-1, the counter holds at all-ones and sat_flag is set. sat_flag clears only on rst or clr.
- **Window mode (win_len != 0):**
  - wcnt counts enabled cycles.
  - On an enabled cycle with wcnt == win_len-1, the snapshot bank loads the live values including that cycle's increments.
  - In the same cycle, the live counters and wcnt load 0.
  - snap_req is ignored.
- **Request mode (win_len == 0):**
  - snap_req=1 loads the snapshot bank the same way, whether or not en is high.
  - Live counters keep running; they are not cleared.
  - If en=0, the snapshot loads the held values.
- **clr coinciding with a snapshot event:** the snapshot is still taken, and the live counters clear.
- **Read map:**
  - rd_sel 0 = cyc.
  - rd_sel 1..NUM_THREADS = inst[0..NUM_THREADS-1].
  - rd_sel NUM_THREADS+1..2*NUM_THREADS = br[0..].
  - Any other rd_sel value reads 0.
- **win_len changed mid-window:** wcnt is not reset. If wcnt already exceeds the new win_len-1, the window ends when wcnt wraps at 2^WIN_W.

## Timing
- **Reset (rst=1 at a clk edge):** all live counters, the snapshot bank, wcnt, rd_data, snap_valid and sat_flag become 0 at that edge. Reset overrides clr, en and snapshot events.
- **Counter update:** live counters update at the edge that samples the lane inputs.
- **Snapshot:** the snapshot bank updates at the event edge; snap_valid is high for exactly the following cycle.
- **Read latency:** rd_data = snapshot[rd_sel as sampled at edge N], valid after edge N+1 (1-cycle latency). A read in the cycle after a snapshot returns the new value.
- **Back-to-back snapshots:** one snapshot every cycle (request mode with snap_req held high, or window mode with win_len=1) produces one snap_valid pulse per cycle, and snap_valid stays high.

## Structure
- The shared package `types` holds:
  - NUM_ALUS and NUM_THREADS defaults.
  - Opcode-class constants: OH_JAL=3, OH_JALR=4, OH_BR_LO=5, OH_BR_HI=10.
  - enum perf_sel_e for the read map.
- Sub-module `perf_sat_counter` is instantiated 2*NUM_THREADS+1 times:
  - Parameters: CNT_W and INC_W=$clog2(NUM_ALUS+1).
  - Inputs: inc, en, clr.
  - Outputs: cnt, sat.
- The top level holds:
  - Lane decode and per-thread population count.
  - The window counter.
  - The snapshot bank and read mux.

## Test plan
- **Reset:** reset, then en=1, win_len=0, no valid lanes for 10 cycles, snap_req=1 -> rd_sel 0 reads 10, every other rd_sel reads 0, snap_valid pulses once.
- **Idle and bubble filtering:** NUM_ALUS=3. Hold lanes at tid {0,0,2} with oh {5,3,0}, jump_en {1,0,0}, for 20 cycles, then snap -> inst[0]=40, br[0]=40, inst[2]=0. The same pattern with tid=4 on all lanes counts nothing.
- **Window mode:** win_len=8, one valid taken lane for thread 1 every cycle -> snap_valid every 8 cycles. Each snapshot reads cyc=8, inst[1]=8, br[1]=8. Live counters restart at 0.
- **Saturation:** CNT_W=4, 3 valid lanes on thread 3 per cycle -> after 5 cycles inst[3]=15 and sat_flag=1. After clr, sat_flag=0 and counting resumes from 0.
- **Simultaneous events:** clr together with the window-final cycle -> snapshot holds full window counts and live counters are 0. rst asserted mid-window -> all outputs 0 at the next edge, and no snap_valid.
- **Enable gating:** en=0 for 5 of 20 cycles in window mode with win_len=20 -> the window ends after 20 enabled cycles and the snapshot reads cyc=20.

Source files
------------

// File: rtl/perf_monitor_pkg.sv
// Shared definitions for the per-thread performance monitor: defaults, opcode-class
// constants and the read-map region decode.
package types;

  localparam int NUM_ALUS_DEFAULT    = 3;
  localparam int NUM_THREADS_DEFAULT = 4;

  localparam int OH_JAL   = 3;
  localparam int OH_JALR  = 4;
  localparam int OH_BR_LO = 5;
  localparam int OH_BR_HI = 10;

  typedef enum logic [1:0] {
    PSEL_CYC  = 2'd0,
    PSEL_INST = 2'd1,
    PSEL_BR   = 2'd2,
    PSEL_NONE = 2'd3
  } perf_sel_e;

  function automatic perf_sel_e sel_region(input int sel, input int num_threads);
    if (sel == 0)                return PSEL_CYC;
    if (sel <= num_threads)      return PSEL_INST;
    if (sel <= 2 * num_threads)  return PSEL_BR;
    return PSEL_NONE;
  endfunction

  // Jumps always redirect; conditional branches only when the ALU resolved them taken.
  function automatic logic is_taken(input int oh, input logic jump_en);
    return (oh == OH_JAL) || (oh == OH_JALR) ||
           ((oh >= OH_BR_LO) && (oh <= OH_BR_HI) && jump_en);
  endfunction

endpackage

// File: rtl/perf_monitor_sat_counter.sv
// Saturating event counter. cnt is the live value including this cycle's increment,
// so a snapshot taken on the same edge sees it; sat flags a count reaching all-ones.
module perf_sat_counter #(
  parameter int CNT_W = 32,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W:0] ALL_ONES = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] value;
  logic [CNT_W:0]   sum;

  always_comb begin
    // NOTE: outputs get a default before any conditional update so no latch is inferred.
    sum = {1'b0, value} + (CNT_W+1)'(inc);
    sat = en && (sum >= ALL_ONES);
    cnt = value;
    if (en) cnt = (sum > ALL_ONES) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst || clr) value <= '0;
    else            value <= cnt;
  end

endmodule

// File: rtl/perf_monitor.sv
// Per-thread performance monitor: decodes ALU dispatch lanes, accumulates cycles,
// instructions and taken branches per thread, and exports them via a snapshot bank.
module perf_monitor
  import types::*;
#(
  parameter int NUM_ALUS    = NUM_ALUS_DEFAULT,
  parameter int NUM_THREADS = NUM_THREADS_DEFAULT,
  parameter int TID_W       = 3,
  parameter int OH_W        = 7,
  parameter int CNT_W       = 32,
  parameter int WIN_W       = 16,
  parameter int SEL_W       = $clog2(2*NUM_THREADS+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [WIN_W-1:0]          win_len,
  input  logic                      snap_req,
  input  logic [NUM_ALUS*TID_W-1:0] alu_tid,
  input  logic [NUM_ALUS*OH_W-1:0]  alu_oh,
  input  logic [NUM_ALUS-1:0]       alu_jump_en,
  input  logic [SEL_W-1:0]          rd_sel,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      snap_valid,
  output logic                      sat_flag
);

  // Counter index matches the read map: 0 = cyc, 1..T = inst[t], T+1..2T = br[t].
  localparam int NUM_CNT = 2 * NUM_THREADS + 1;
  localparam int INC_W   = $clog2(NUM_ALUS + 1);

  logic [TID_W-1:0]    lane_tid [NUM_ALUS];
  logic [NUM_ALUS-1:0] lane_valid;
  logic [NUM_ALUS-1:0] lane_taken;
  logic [INC_W-1:0]    inc_vec  [NUM_CNT];
  logic [CNT_W-1:0]    cnt_vec  [NUM_CNT];
  logic [NUM_CNT-1:0]  sat_vec;
  logic [CNT_W-1:0]    snap_bank [NUM_CNT];
  logic [WIN_W-1:0]    wcnt;

  logic win_mode;
  logic win_end;
  logic snap_event;
  logic live_clr;

  always_comb begin
    for (int i = 0; i < NUM_ALUS; i++) begin
      lane_tid[i]   = alu_tid[i*TID_W +: TID_W];
      lane_valid[i] = (int'(lane_tid[i]) < NUM_THREADS) && (alu_oh[i*OH_W +: OH_W] != '0);
      lane_taken[i] = lane_valid[i] && is_taken(int'(alu_oh[i*OH_W +: OH_W]), alu_jump_en[i]);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) inc_vec[k] = '0;
    inc_vec[0] = INC_W'(1);
    for (int i = 0; i < NUM_ALUS; i++) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (lane_valid[i] && (int'(lane_tid[i]) == t))
          inc_vec[1+t] = inc_vec[1+t] + INC_W'(1);
        if (lane_taken[i] && (int'(lane_tid[i]) == t))
          inc_vec[1+NUM_THREADS+t] = inc_vec[1+NUM_THREADS+t] + INC_W'(1);
      end
    end
  end

  assign win_mode   = (win_len != '0);
  assign win_end    = win_mode && en && (wcnt == win_len - WIN_W'(1));
  assign snap_event = win_mode ? win_end : snap_req;
  assign live_clr   = clr || win_end;

  // A shortened win_len does not reset wcnt; the window then closes only after wrap-around.
  always_ff @(posedge clk) begin
    if (rst || clr || !win_mode || win_end) wcnt <= '0;
    else if (en)                            wcnt <= wcnt + WIN_W'(1);
  end

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    perf_sat_counter #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .clr (live_clr),
      .inc (inc_vec[k]),
      .cnt (cnt_vec[k]),
      .sat (sat_vec[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the snapshot bank is reset so a read before the first snapshot returns 0.
      for (int k = 0; k < NUM_CNT; k++) snap_bank[k] <= '0;
      snap_valid <= 1'b0;
      rd_data    <= '0;
      sat_flag   <= 1'b0;
    end else begin
      if (snap_event) begin
        for (int k = 0; k < NUM_CNT; k++) snap_bank[k] <= cnt_vec[k];
      end
      snap_valid <= snap_event;
      case (sel_region(int'(rd_sel), NUM_THREADS))
        PSEL_NONE: rd_data <= '0;
        default:   rd_data <= snap_bank[rd_sel];
      endcase
      if (clr)           sat_flag <= 1'b0;
      else if (|sat_vec) sat_flag <= 1'b1;
    end
  end

endmodule
